// File: rtl/sign_narrower_pkg.sv
// Shared widths and FSM encoding for the 24->12 narrowing stage.
// IN_W/OUT_W defaults match the 12->24 sign extender.
package sign_narrower_pkg;

  localparam int unsigned DefInW  = 24;
  localparam int unsigned DefOutW = 12;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StOut  = 2'd2
  } state_e;

endpackage

// File: rtl/sign_narrower_core.sv
// Combinational fit test plus wrap/saturate selection for two's-complement narrowing.
module narrow_core #(
  parameter int unsigned IN_W  = 24,
  parameter int unsigned OUT_W = 12
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_sat,
  output logic [OUT_W-1:0] data,
  output logic             ovf
);

  // Value fits iff every bit from the new sign position upwards agrees.
  logic [IN_W-OUT_W:0] top_bits;
  logic                fits;

  assign top_bits = in_data[IN_W-1:OUT_W-1];
  assign fits     = (&top_bits) | ~(|top_bits);

  always_comb begin
    data = in_data[OUT_W-1:0];
    ovf  = ~fits;
    if (!fits && in_sat) begin
      data = in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/sign_narrower.sv
// Valid/ready wrapper around narrow_core: IDLE/CALC/OUT handshake FSM plus
// sticky overflow flag and saturating overflow counter.
module sign_narrower
  import sign_narrower_pkg::*;
#(
  parameter int unsigned IN_W  = DefInW,
  parameter int unsigned OUT_W = DefOutW,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_ovf
);

  state_e             state_q, state_d;
  logic [IN_W-1:0]    data_q, data_d;
  logic               sat_q, sat_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_ovf_q, out_ovf_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [OUT_W-1:0]   core_data;
  logic               core_ovf;

  narrow_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_data (data_q),
    .in_sat  (sat_q),
    .data    (core_data),
    .ovf     (core_ovf)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    sat_d      = sat_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    sticky_d   = sticky_q;
    count_d    = count_q;

    // Clear is applied before any same-cycle overflow update.
    if (clr_ovf) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data;
          sat_d   = in_sat;
          state_d = StCalc;
        end
      end
      StCalc: begin
        out_data_d = core_data;
        out_ovf_d  = core_ovf;
        state_d    = StOut;
        if (core_ovf) begin
          sticky_d = 1'b1;
          if (count_d != {CNT_W{1'b1}}) count_d = count_d + CNT_W'(1);
        end
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      data_q     <= '0;
      sat_q      <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      sat_q      <= sat_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StOut);
  assign out_data   = out_data_q;
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = sticky_q;
  assign ovf_count  = count_q;

endmodule

// File: tb/tb_sign_narrower.sv
// Self-checking bench for sign_narrower: directed cases plus randomized values
// compared against an arithmetic range model of 24->12 narrowing.
module tb_sign_narrower;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        in_sat;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        out_ovf;
  logic        ovf_sticky;
  logic [7:0]  ovf_count;
  logic        clr_ovf;

  int n_cmp = 0;
  int n_err = 0;

  bit          m_sticky;
  int          m_count;
  logic [11:0] last_data;
  logic        last_ovf;

  sign_narrower dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sat     (in_sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  // {ovf, data}: representable range of a 12-bit signed field is -2048..2047.
  function automatic logic [12:0] model(input logic [23:0] d, input logic s);
    int v;
    logic [11:0] r;
    logic        o;
    v = int'($signed(d));
    o = (v > 2047) || (v < -2048);
    r = d[11:0];
    if (o && s) r = (v < 0) ? 12'h800 : 12'h7FF;
    return {o, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_sticky"}, 32'(ovf_sticky), 32'(m_sticky));
    chk({tag, "_count"}, 32'(ovf_count), 32'(m_count));
  endtask

  // One full transfer. hold = cycles out_ready stays low in OUT; pend drives a
  // competing in_valid during the hold; clr pulses clr_ovf on the CALC->OUT edge.
  task automatic send(input logic [23:0] d, input logic s, input int hold,
                      input logic clr, input logic pend);
    logic [12:0] m;
    m = model(d, s);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_data   = d;
    in_sat    = s;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    chk("in_ready_calc", 32'(in_ready), 32'd0);
    chk("out_valid_calc", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    in_data  = 24'($urandom);
    in_sat   = 1'($urandom);
    clr_ovf  = clr;
    step();
    clr_ovf = 1'b0;
    if (clr) begin
      m_sticky = 1'b0;
      m_count  = 0;
    end
    if (m[12]) begin
      m_sticky = 1'b1;
      if (m_count < 255) m_count++;
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_data", 32'(out_data), 32'(m[11:0]));
    chk("out_ovf", 32'(out_ovf), 32'(m[12]));
    check_stats("xfer");
    last_data = out_data;
    last_ovf  = out_ovf;
    if (pend) begin
      in_valid = 1'b1;
      in_data  = 24'h000123;
      in_sat   = 1'b0;
    end
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(m[11:0]));
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    m_sticky  = 1'b0;
    m_count   = 0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sat    = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    m_sticky  = 1'b0;
    m_count   = 0;
    step();
    step();
    reset = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    check_stats("rst");

    // Plain fit, wrap mode.
    send(24'd15, 1'b0, 0, 1'b0, 1'b0);
    chk("t1_data", 32'(last_data), 32'h00F);
    chk("t1_ovf", 32'(last_ovf), 32'd0);

    // Negative value that fits; saturate mode must not touch it.
    send(24'hFFFE0C, 1'b1, 0, 1'b0, 1'b0);
    chk("t2_data", 32'(last_data), 32'hE0C);
    chk("t2_sticky", 32'(ovf_sticky), 32'd0);

    // Just-out-of-range boundaries.
    send(24'h000800, 1'b1, 0, 1'b0, 1'b0);
    chk("t3a_data", 32'(last_data), 32'h7FF);
    send(24'h000800, 1'b0, 0, 1'b0, 1'b0);
    chk("t3b_data", 32'(last_data), 32'h800);
    chk("t3b_ovf", 32'(last_ovf), 32'd1);
    send(24'hFFF7FF, 1'b1, 0, 1'b0, 1'b0);
    chk("t3c_data", 32'(last_data), 32'h800);
    chk("t3_count", 32'(ovf_count), 32'd3);

    // Backpressure with a competing producer; held value taken afterwards.
    send(24'h000042, 1'b0, 5, 1'b0, 1'b1);
    send(24'h000123, 1'b0, 0, 1'b0, 1'b0);
    chk("t4_data", 32'(last_data), 32'h123);

    // Clear colliding with an overflow update.
    send(24'h7FFFFF, 1'b1, 0, 1'b1, 1'b0);
    chk("t5_sticky", 32'(ovf_sticky), 32'd1);
    chk("t5_count", 32'(ovf_count), 32'd1);

    // Clear on its own.
    clr_ovf = 1'b1;
    step();
    clr_ovf  = 1'b0;
    m_sticky = 1'b0;
    m_count  = 0;
    check_stats("clr");

    // Counter saturation.
    for (int i = 0; i < 300; i++) send(24'h400000, 1'($urandom), 0, 1'b0, 1'b0);
    chk("t5_sat_count", 32'(ovf_count), 32'hFF);

    // Randomized values, biased toward the representable boundary.
    for (int i = 0; i < 150; i++) begin
      logic [23:0] d;
      case ($urandom_range(0, 2))
        0:       d = 24'(int'($urandom_range(0, 4095)) - 2048);
        1:       d = 24'(($urandom_range(0, 1) ? 2048 : -2048) + int'($urandom_range(0, 7)) - 4);
        default: d = 24'($urandom);
      endcase
      send(d, 1'($urandom), int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0), 1'b0);
    end

    // Reset while in CALC.
    in_data  = 24'h800000;
    in_sat   = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    do_reset();
    chk("t6a_in_ready", 32'(in_ready), 32'd1);
    chk("t6a_out_valid", 32'(out_valid), 32'd0);
    check_stats("t6a");

    // Reset while in OUT.
    send(24'h000900, 1'b0, 0, 1'b0, 1'b0);
    in_data  = 24'h000900;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("t6b_pre_valid", 32'(out_valid), 32'd1);
    do_reset();
    chk("t6b_in_ready", 32'(in_ready), 32'd1);
    chk("t6b_out_valid", 32'(out_valid), 32'd0);
    chk("t6b_out_data", 32'(out_data), 32'd0);
    check_stats("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
